// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the multicycle datapath.
// Runs MULT, MULTU, DIV and DIVU on operands captured at start. Each op takes one
// radix-2 step per cycle for WIDTH cycles, then one sign-fix cycle. Results are
// held in HI/LO, which can also be loaded directly with MTHI/MTLO while idle.
//
// Ports:
//   clock, reset_l       rising-edge clock, asynchronous active-low reset
//   start, op            request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a_in, b_in           operand A (multiplicand/dividend), B (multiplier/divisor)
//   mthi, mtlo, wdata    direct HI/LO load, honoured only in IDLE without start
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse when HI/LO are final
//   div_zero             valid with done; divide with zero divisor
//   hi, lo               HI (product high / remainder), LO (product low / quotient)
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;  // negate product / quotient
    logic               neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand magnitudes for signed ops; the most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a_in[WIDTH-1];
    assign b_neg     = signed_op & b_in[WIDTH-1];
    assign a_mag     = a_neg ? (~a_in + 1'b1) : a_in;
    assign b_mag     = b_neg ? (~b_in + 1'b1) : b_in;

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Restoring step: shift the next dividend bit into the remainder, trial subtract.
    assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_tmp - {1'b0, b_q};

    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        div_d      = div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    div_d     = op[1];
                    b_d       = b_mag;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (op[1] && (b_in == '0)) begin
                        div_zero_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            StCalc: begin
                if (div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StDone;
            end
            StDone: begin
                div_zero_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            div_q      <= div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
